// File: rtl/demux1a8_tdm_pkg.sv
// Shared types and constants for the 1:8 TDM demultiplexer.
// Lane count, slot width, lock states and default miss tolerance.
package demux1a8_tdm_pkg;

  localparam int LANES          = 8;
  localparam int SLOT_W         = 3;
  localparam int MISS_LIMIT_DEF = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux_slot_ctr.sv
// TDM slot counter: clear, load-to-1 and wrapping increment.
// Priority is clr > load1 > inc; idle otherwise.
module demux_slot_ctr
  import demux1a8_tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/demux1a8_tdm.sv
// 1:8 TDM demultiplexer with frame lock, flywheel and resync.
// One serial bit per enabled slot; full frames leave on dout.
module demux1a8_tdm
  import demux1a8_tdm_pkg::*;
#(
  parameter int MISS_LIMIT = MISS_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              din,
  input  logic              frame_sync,
  output logic [SLOT_W-1:0] slot,
  output logic [LANES-1:0]  dout,
  output logic              dout_valid,
  output logic              locked,
  output logic              sync_err
);

  state_t           state;
  logic [LANES-1:0] sbuf;
  logic [2:0]       miss;

  logic s0;
  logic last;
  logic miss_hit;
  logic a_resync;
  logic a_s0_sync;
  logic a_s0_drop;
  logic a_s0_fly;
  logic a_last;
  logic a_mid;
  logic ctr_clr;
  logic ctr_ld1;
  logic ctr_inc;

  assign s0       = (slot == '0);
  assign last     = (slot == SLOT_W'(LANES - 1));
  assign miss_hit = ({1'b0, miss} + 4'd1) >= 4'(MISS_LIMIT);
  assign locked   = (state == LOCKED);

  // Disjoint LOCKED actions; a sync pulse off slot 0 always wins.
  assign a_resync  = frame_sync & ~s0;
  assign a_s0_sync = frame_sync & s0;
  assign a_s0_drop = ~frame_sync & s0 & miss_hit;
  assign a_s0_fly  = ~frame_sync & s0 & ~miss_hit;
  assign a_last    = ~frame_sync & last;
  assign a_mid     = ~frame_sync & ~s0 & ~last;

  always_comb begin
    ctr_clr = 1'b0;
    ctr_ld1 = 1'b0;
    ctr_inc = 1'b0;
    if (en) begin
      if (state == HUNT) begin
        ctr_ld1 = frame_sync;
        ctr_clr = ~frame_sync;
      end else begin
        ctr_ld1 = a_resync;
        ctr_clr = a_s0_drop;
        ctr_inc = ~a_resync & ~a_s0_drop;
      end
    end
  end

  demux_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ctr_clr),
    .load1 (ctr_ld1),
    .inc   (ctr_inc),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      sbuf       <= '0;
      miss       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (en) begin
        if (state == HUNT) begin
          if (frame_sync) begin
            sbuf[0] <= din;
            miss    <= '0;
            state   <= LOCKED;
          end
        end else begin
          unique case (1'b1)
            a_resync: begin
              sync_err <= 1'b1;
              sbuf[0]  <= din;
              miss     <= '0;
            end
            a_s0_sync: begin
              sbuf[0] <= din;
              miss    <= '0;
            end
            a_s0_drop: begin
              state <= HUNT;
              miss  <= '0;
            end
            a_s0_fly: begin
              sbuf[0] <= din;
              miss    <= miss + 3'd1;
            end
            a_last: begin
              dout       <= {din, sbuf[LANES-2:0]};
              dout_valid <= 1'b1;
            end
            a_mid: begin
              sbuf[slot] <= din;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_demux1a8_tdm.sv
// Scoreboard bench for demux1a8_tdm.
// Expected frames queued at drive time, popped on dout_valid.
module tb_demux1a8_tdm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       frame_sync;
  logic [2:0] slot;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic       sync_err;

  int n_cmp;
  int n_bad;
  int n_pulse;
  logic [7:0] exp_q[$];

  demux1a8_tdm #(.MISS_LIMIT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .frame_sync (frame_sync),
    .slot       (slot),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        check("unexp_valid", 32'(dout), 32'hdead);
      end else begin
        check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic e, input logic fs, input logic d);
    en         = e;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic stall_chk();
    logic [2:0] s;
    s = slot;
    drive(1'b0, 1'b0, 1'b0);
    check("stall_slot", 32'(slot), 32'(s));
  endtask

  task automatic send_frame(input logic [7:0] v,
                            input logic fs0,
                            input logic gap,
                            input logic expect_out);
    logic [7:0] vv;
    vv = v;
    for (int k = 0; k < 8; k++) begin
      if (k == 7 && expect_out) exp_q.push_back(vv);
      drive(1'b1, fs0 && (k == 0), vv[k]);
      if (gap) stall_chk();
    end
  endtask

  initial begin
    int p0;
    n_cmp = 0; n_bad = 0; n_pulse = 0;
    en = 0; din = 0; frame_sync = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_slot", 32'(slot), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(sync_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle hunting slots, then first locked frame.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      check("hunt_slot", 32'(slot), 0);
      check("hunt_lock", 32'(locked), 0);
    end
    send_frame(8'h96, 1'b1, 1'b0, 1'b1);
    check("f1_dout", 32'(dout), 32'h96);
    check("f1_valid", 32'(dout_valid), 1);
    check("f1_lock", 32'(locked), 1);
    drive(1'b0, 1'b0, 1'b0);
    check("f1_valid_off", 32'(dout_valid), 0);
    check("f1_hold", 32'(dout), 32'h96);

    // Back-to-back frames with en toggling.
    p0 = n_pulse;
    send_frame(8'h96, 1'b1, 1'b1, 1'b1);
    check("f2_dout", 32'(dout), 32'h96);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check("f3_dout", 32'(dout), 32'h3C);
    check("b2b_pulses", 32'(n_pulse - p0), 2);

    // Misplaced sync at slot 5 restarts the frame.
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 1'b1);
    check("pre_rs_slot", 32'(slot), 5);
    check("pre_rs_err", 32'(sync_err), 0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    check("rs_dout", 32'(dout), 32'hA5);
    check("rs_err", 32'(sync_err), 1);
    check("rs_lock", 32'(locked), 1);

    // Flywheel one frame, drop lock on the second miss.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("fly_dout", 32'(dout), 32'h5A);
    check("fly_lock", 32'(locked), 1);
    drive(1'b1, 1'b0, 1'b1);
    check("drop_lock", 32'(locked), 0);
    check("drop_slot", 32'(slot), 0);
    check("drop_dout", 32'(dout), 32'h5A);
    drive(1'b1, 1'b0, 1'b0);
    check("drop_hunt", 32'(slot), 0);
    check("err_sticky", 32'(sync_err), 1);

    // Relock, then async reset mid-frame.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 1'b1);
    check("pre_rst_slot", 32'(slot), 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_slot", 32'(slot), 0);
    check("arst_dout", 32'(dout), 0);
    check("arst_lock", 32'(locked), 0);
    check("arst_err", 32'(sync_err), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    check("nosync_lock", 32'(locked), 0);
    check("nosync_dout", 32'(dout), 0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    check("ff_dout", 32'(dout), 32'hFF);

    repeat (3) drive(1'b0, 1'b0, 1'b0);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
